// File: rtl/fare_gate_ctrl.sv
// Fare gate lane controller: validates a tapped card, charges the fare and
// sequences gate, display and sounder, with a maintenance service mode.
module fare_gate_ctrl #(
   parameter int                BAL_W     = 16,
   parameter logic [BAL_W-1:0]  FARE      = BAL_W'(310),
   parameter logic [BAL_W-1:0]  CONC_FARE = BAL_W'(205),
   parameter int                OPEN_CYC  = 8,
   parameter int                MSG_CYC   = 4,
   parameter int                BEEP_CYC  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tap,
   input  logic             card_active,
   input  logic             card_monthly,
   input  logic             card_concession,
   input  logic [BAL_W-1:0] card_bal,
   input  logic             maintenance,
   input  logic             pass_sensor,
   output logic             open,
   output logic [2:0]       disp,
   output logic [1:0]       sound,
   output logic             bal_we,
   output logic [BAL_W-1:0] bal_out,
   output logic             busy
);

   localparam int MAX_CYC = (OPEN_CYC > MSG_CYC) ? OPEN_CYC : MSG_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam int BEEP_W  = $clog2(BEEP_CYC + 1);

   localparam logic [CNT_W-1:0]  OPEN_LAST = CNT_W'(OPEN_CYC - 1);
   localparam logic [CNT_W-1:0]  MSG_LAST  = CNT_W'(MSG_CYC - 1);
   localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_CYC - 1);

   localparam logic [2:0] DISP_IDLE    = 3'b000;
   localparam logic [2:0] DISP_FUNDS   = 3'b001;
   localparam logic [2:0] DISP_INVALID = 3'b010;
   localparam logic [2:0] DISP_BAL     = 3'b100;
   localparam logic [2:0] DISP_MONTHLY = 3'b101;
   localparam logic [2:0] DISP_SERV    = 3'b111;

   localparam logic [1:0] SND_NONE = 2'b00;
   localparam logic [1:0] SND_ERR  = 2'b01;
   localparam logic [1:0] SND_PASS = 2'b10;

   typedef enum logic [2:0] {IDLE, CHECK, CHARGE, OPEN, MSG, SERV} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [BEEP_W-1:0] beep_cnt;
   logic              cap_active;
   logic              cap_monthly;
   logic              cap_concession;
   logic [BAL_W-1:0]  cap_bal;
   logic [BAL_W-1:0]  fare;

   assign fare = cap_concession ? CONC_FARE : FARE;

   // Counters hold "cycles remaining minus one", so zero marks the last cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= '0;
         beep_cnt       <= '0;
         cap_active     <= 1'b0;
         cap_monthly    <= 1'b0;
         cap_concession <= 1'b0;
         cap_bal        <= '0;
         open           <= 1'b0;
         disp           <= DISP_IDLE;
         sound          <= SND_NONE;
         bal_we         <= 1'b0;
         bal_out        <= '0;
         busy           <= 1'b0;
      end else begin
         bal_we <= 1'b0;
         case (state)
            IDLE: begin
               if (maintenance) begin
                  state <= SERV;
                  disp  <= DISP_SERV;
               end else if (tap) begin
                  cap_active     <= card_active;
                  cap_monthly    <= card_monthly;
                  cap_concession <= card_concession;
                  cap_bal        <= card_bal;
                  state          <= CHECK;
                  busy           <= 1'b1;
               end
            end
            CHECK: begin
               if (!cap_active) begin
                  state    <= MSG;
                  disp     <= DISP_INVALID;
                  sound    <= SND_ERR;
                  beep_cnt <= BEEP_LAST;
                  cnt      <= MSG_LAST;
               end else if (cap_monthly) begin
                  state    <= OPEN;
                  open     <= 1'b1;
                  disp     <= DISP_MONTHLY;
                  sound    <= SND_PASS;
                  beep_cnt <= BEEP_LAST;
                  cnt      <= OPEN_LAST;
               end else if (cap_bal >= fare) begin
                  state   <= CHARGE;
                  bal_we  <= 1'b1;
                  bal_out <= cap_bal - fare;
               end else begin
                  state    <= MSG;
                  disp     <= DISP_FUNDS;
                  sound    <= SND_ERR;
                  beep_cnt <= BEEP_LAST;
                  cnt      <= MSG_LAST;
               end
            end
            CHARGE: begin
               state    <= OPEN;
               open     <= 1'b1;
               disp     <= DISP_BAL;
               sound    <= SND_PASS;
               beep_cnt <= BEEP_LAST;
               cnt      <= OPEN_LAST;
            end
            OPEN: begin
               if (pass_sensor || cnt == '0) begin
                  state    <= IDLE;
                  open     <= 1'b0;
                  disp     <= DISP_IDLE;
                  sound    <= SND_NONE;
                  beep_cnt <= '0;
                  cnt      <= '0;
                  busy     <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
                  // A repeat tap is an anti-passback attempt: error beep, no charge.
                  if (tap) begin
                     sound    <= SND_ERR;
                     beep_cnt <= BEEP_LAST;
                  end else if (beep_cnt == '0) begin
                     sound <= SND_NONE;
                  end else begin
                     beep_cnt <= beep_cnt - BEEP_W'(1);
                  end
               end
            end
            MSG: begin
               if (cnt == '0) begin
                  state    <= IDLE;
                  disp     <= DISP_IDLE;
                  sound    <= SND_NONE;
                  beep_cnt <= '0;
                  busy     <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
                  if (beep_cnt == '0) begin
                     sound <= SND_NONE;
                  end else begin
                     beep_cnt <= beep_cnt - BEEP_W'(1);
                  end
               end
            end
            SERV: begin
               if (!maintenance) begin
                  state    <= IDLE;
                  disp     <= DISP_IDLE;
                  sound    <= SND_NONE;
                  beep_cnt <= '0;
               end else if (tap) begin
                  sound    <= SND_ERR;
                  beep_cnt <= BEEP_LAST;
               end else if (beep_cnt == '0) begin
                  sound <= SND_NONE;
               end else begin
                  beep_cnt <= beep_cnt - BEEP_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fare_gate_ctrl.sv
// Bench for fare_gate_ctrl: a timeline model of each transaction is compared
// every cycle, with directed scenarios pinning hand-computed values.
module tb_fare_gate_ctrl;

   localparam int BAL_W     = 16;
   localparam int FARE      = 310;
   localparam int CONC_FARE = 205;
   localparam int OPEN_CYC  = 8;
   localparam int MSG_CYC   = 4;
   localparam int BEEP_CYC  = 2;

   localparam int K_PAY = 0;
   localparam int K_MON = 1;
   localparam int K_ERR = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             tap;
   logic             card_active;
   logic             card_monthly;
   logic             card_concession;
   logic [BAL_W-1:0] card_bal;
   logic             maintenance;
   logic             pass_sensor;
   logic             open;
   logic [2:0]       disp;
   logic [1:0]       sound;
   logic             bal_we;
   logic [BAL_W-1:0] bal_out;
   logic             busy;

   int errors = 0;
   int checks = 0;

   // Model: a transaction is described by its tap cycle and the absolute
   // cycles at which the gate opens, the transaction ends and an error beep runs.
   bit               m_valid    = 1'b0;
   bit               in_txn     = 1'b0;
   bit               in_serv    = 1'b0;
   int               cyc        = 0;
   int               t0         = 0;
   int               kind       = 0;
   int               open_start = 0;
   int               txn_end    = 0;
   int               err_start  = 0;
   int               err_end    = 0;
   logic [2:0]       m_code     = 3'b000;
   logic [BAL_W-1:0] m_bal      = '0;
   logic [BAL_W-1:0] new_bal    = '0;

   always #5 clk = ~clk;

   fare_gate_ctrl #(
      .BAL_W     (BAL_W),
      .FARE      (BAL_W'(FARE)),
      .CONC_FARE (BAL_W'(CONC_FARE)),
      .OPEN_CYC  (OPEN_CYC),
      .MSG_CYC   (MSG_CYC),
      .BEEP_CYC  (BEEP_CYC)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .tap             (tap),
      .card_active     (card_active),
      .card_monthly    (card_monthly),
      .card_concession (card_concession),
      .card_bal        (card_bal),
      .maintenance     (maintenance),
      .pass_sensor     (pass_sensor),
      .open            (open),
      .disp            (disp),
      .sound           (sound),
      .bal_we          (bal_we),
      .bal_out         (bal_out),
      .busy            (busy)
   );

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Advance the model by one clock using the inputs the DUT is about to sample.
   task automatic model_step();
      int c;
      int fare;
      c = cyc;
      if (rst) begin
         m_valid   = 1'b1;
         in_txn    = 1'b0;
         in_serv   = 1'b0;
         m_bal     = '0;
         err_start = 0;
         err_end   = 0;
      end else if (in_txn) begin
         if (kind != K_ERR && c >= open_start) begin
            if (pass_sensor) begin
               txn_end = c + 1;
            end else if (tap) begin
               err_start = c + 1;
               err_end   = c + 1 + BEEP_CYC;
            end
         end
         if (kind == K_PAY && c + 1 == t0 + 2) m_bal = new_bal;
         if (c + 1 == txn_end) in_txn = 1'b0;
      end else if (in_serv) begin
         if (!maintenance) begin
            in_serv = 1'b0;
         end else if (tap) begin
            err_start = c + 1;
            err_end   = c + 1 + BEEP_CYC;
         end
      end else if (maintenance) begin
         in_serv   = 1'b1;
         err_start = 0;
         err_end   = 0;
      end else if (tap) begin
         in_txn    = 1'b1;
         t0        = c;
         err_start = 0;
         err_end   = 0;
         fare      = card_concession ? CONC_FARE : FARE;
         if (!card_active) begin
            kind    = K_ERR;
            m_code  = 3'b010;
            txn_end = c + 2 + MSG_CYC;
         end else if (card_monthly) begin
            kind       = K_MON;
            m_code     = 3'b101;
            open_start = c + 2;
            txn_end    = open_start + OPEN_CYC;
         end else if (int'(card_bal) >= fare) begin
            kind       = K_PAY;
            m_code     = 3'b100;
            new_bal    = BAL_W'(int'(card_bal) - fare);
            open_start = c + 3;
            txn_end    = open_start + OPEN_CYC;
         end else begin
            kind    = K_ERR;
            m_code  = 3'b001;
            txn_end = c + 2 + MSG_CYC;
         end
      end
      cyc = c + 1;
   endtask

   task automatic check_output();
      logic       e_open;
      logic       e_we;
      logic       e_busy;
      logic [2:0] e_disp;
      logic [1:0] e_sound;
      bit         err_on;
      e_open  = 1'b0;
      e_we    = 1'b0;
      e_busy  = 1'b0;
      e_disp  = 3'b000;
      e_sound = 2'b00;
      if (!m_valid) return;
      err_on = (cyc >= err_start) && (cyc < err_end);
      if (in_txn) begin
         e_busy = 1'b1;
         e_we   = (kind == K_PAY) && (cyc == t0 + 2);
         if (kind == K_ERR) begin
            if (cyc >= t0 + 2) begin
               e_disp  = m_code;
               e_sound = (cyc < t0 + 2 + BEEP_CYC) ? 2'b01 : 2'b00;
            end
         end else if (cyc >= open_start) begin
            e_open = 1'b1;
            e_disp = m_code;
            if (err_on) e_sound = 2'b01;
            else if (cyc < open_start + BEEP_CYC) e_sound = 2'b10;
         end
      end else if (in_serv) begin
         e_disp = 3'b111;
         if (err_on) e_sound = 2'b01;
      end
      cmp("open",    32'(open),    32'(e_open));
      cmp("disp",    32'(disp),    32'(e_disp));
      cmp("sound",   32'(sound),   32'(e_sound));
      cmp("bal_we",  32'(bal_we),  32'(e_we));
      cmp("bal_out", 32'(bal_out), 32'(m_bal));
      cmp("busy",    32'(busy),    32'(e_busy));
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         model_step();
         @(negedge clk);
         check_output();
      end
   endtask

   task automatic tap_card(input logic a, input logic m, input logic c, input int b);
      tap             = 1'b1;
      card_active     = a;
      card_monthly    = m;
      card_concession = c;
      card_bal        = BAL_W'(b);
      tick();
      tap = 1'b0;
   endtask

   task automatic apply_stimulus();
      int sel;
      rst             = ($urandom_range(0, 299) == 0);
      tap             = ($urandom_range(0, 3) == 0);
      card_active     = ($urandom_range(0, 9) != 0);
      card_monthly    = ($urandom_range(0, 3) == 0);
      card_concession = ($urandom_range(0, 2) == 0);
      sel = int'($urandom_range(0, 5));
      case (sel)
         0:       card_bal = BAL_W'(FARE);
         1:       card_bal = BAL_W'(FARE - 1);
         2:       card_bal = BAL_W'(CONC_FARE);
         3:       card_bal = BAL_W'(CONC_FARE - 1);
         4:       card_bal = '0;
         default: card_bal = BAL_W'($urandom_range(0, 2000));
      endcase
      if ($urandom_range(0, 49) == 0) maintenance = ~maintenance;
      pass_sensor = ($urandom_range(0, 9) == 0);
   endtask

   initial begin
      rst             = 1'b1;
      tap             = 1'b0;
      card_active     = 1'b0;
      card_monthly    = 1'b0;
      card_concession = 1'b0;
      card_bal        = '0;
      maintenance     = 1'b0;
      pass_sensor     = 1'b0;
      tick(2);
      cmp("rst_disp", 32'(disp), 0);
      cmp("rst_busy", 32'(busy), 0);
      rst = 1'b0;
      tick(2);

      $display("[TB] standard fare, balance 1000");
      tap_card(1'b1, 1'b0, 1'b0, 1000);
      cmp("std_busy_check", 32'(busy), 1);
      tick();
      cmp("std_bal_we", 32'(bal_we), 1);
      cmp("std_bal_out", 32'(bal_out), 690);
      tick();
      cmp("std_open_first", 32'(open), 1);
      cmp("std_disp", 32'(disp), 3'b100);
      cmp("std_pass_beep", 32'(sound), 2'b10);
      tick();
      cmp("std_pass_beep2", 32'(sound), 2'b10);
      tick();
      cmp("std_beep_end", 32'(sound), 0);
      tick(5);
      cmp("std_open_last", 32'(open), 1);
      tick();
      cmp("std_closed", 32'(open), 0);
      cmp("std_idle", 32'(busy), 0);

      $display("[TB] reset while gate open");
      tap_card(1'b1, 1'b1, 1'b0, 0);
      tick(3);
      cmp("rst_mid_open_pre", 32'(open), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cmp("rst_mid_open", 32'(open), 0);
      cmp("rst_mid_bal", 32'(bal_out), 0);
      cmp("rst_mid_disp", 32'(disp), 0);
      tick();

      $display("[TB] concession exact fare");
      tap_card(1'b1, 1'b0, 1'b1, 205);
      tick();
      cmp("conc_bal_we", 32'(bal_we), 1);
      cmp("conc_bal_zero", 32'(bal_out), 0);
      tick();
      cmp("conc_open", 32'(open), 1);
      tick(8);
      cmp("conc_idle", 32'(busy), 0);

      $display("[TB] standard fare one cent short");
      tap_card(1'b1, 1'b0, 1'b0, 309);
      tick();
      cmp("short_no_we", 32'(bal_we), 0);
      cmp("short_disp", 32'(disp), 3'b001);
      cmp("short_beep", 32'(sound), 2'b01);
      tick(3);
      cmp("short_disp_last", 32'(disp), 3'b001);
      cmp("short_quiet", 32'(sound), 0);
      tick();
      cmp("short_idle", 32'(disp), 0);

      $display("[TB] monthly pass with sensor");
      tap_card(1'b1, 1'b1, 1'b0, 0);
      tick();
      cmp("mon_open", 32'(open), 1);
      cmp("mon_disp", 32'(disp), 3'b101);
      tick(2);
      pass_sensor = 1'b1;
      tick();
      pass_sensor = 1'b0;
      cmp("mon_closed", 32'(open), 0);

      $display("[TB] blocked card holding monthly pass");
      tap_card(1'b0, 1'b1, 1'b0, 500);
      tick();
      cmp("inv_disp", 32'(disp), 3'b010);
      cmp("inv_open", 32'(open), 0);
      tick(3);
      cmp("inv_disp_last", 32'(disp), 3'b010);
      tick();
      cmp("inv_idle", 32'(disp), 0);

      $display("[TB] anti-passback tap");
      tap_card(1'b1, 1'b1, 1'b0, 0);
      tick(2);
      tap = 1'b1;
      tick();
      tap = 1'b0;
      cmp("apb_beep", 32'(sound), 2'b01);
      cmp("apb_no_we", 32'(bal_we), 0);
      tick();
      cmp("apb_beep2", 32'(sound), 2'b01);
      tick();
      cmp("apb_quiet", 32'(sound), 0);
      tick(3);
      cmp("apb_open_last", 32'(open), 1);
      tick();
      cmp("apb_closed", 32'(open), 0);

      $display("[TB] maintenance with simultaneous tap");
      maintenance = 1'b1;
      tap_card(1'b1, 1'b0, 1'b0, 1000);
      cmp("serv_disp", 32'(disp), 3'b111);
      cmp("serv_busy", 32'(busy), 0);
      tick();
      tap = 1'b1;
      tick();
      tap = 1'b0;
      cmp("serv_beep", 32'(sound), 2'b01);
      tick();
      cmp("serv_beep2", 32'(sound), 2'b01);
      tick();
      cmp("serv_quiet", 32'(sound), 0);
      maintenance = 1'b0;
      tick();
      cmp("serv_exit", 32'(disp), 0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 5000; i++) begin
         apply_stimulus();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fare_gate_ctrl.md
# fare_gate_ctrl

Parametrised next-generation fare gate controller for one SkyTrain faregate lane. It accepts an NFC tap with card attributes and validates the card. It applies monthly, concession or standard fare with internal balance arithmetic, drives the gate, display and sounder for programmable durations, and handles maintenance mode. It sits between the NFC reader/account lookup logic and the gate actuator/display, and writes the new balance back through a one-cycle strobe.

## Interface
- BAL_W, 16, width of balance fields (cents)
- FARE, 310, standard fare (BAL_W bits)
- CONC_FARE, 205, concession fare (BAL_W bits)
- OPEN_CYC, 8, cycles the gate stays open when no passage is detected (≥1)
- MSG_CYC, 4, cycles an error message is held (≥1)
- BEEP_CYC, 2, sound pulse length (1 ≤ BEEP_CYC ≤ min(OPEN_CYC, MSG_CYC))

- clk  in  1  clock; one clock domain; all logic on posedge
- rst  in  1  synchronous, active-high reset
- tap  in  1  one-cycle NFC tap pulse; card_* inputs are valid in the same cycle
- card_active  in  1  account exists and is not blocked
- card_monthly  in  1  valid monthly pass
- card_concession  in  1  concession fare category
- card_bal  in  BAL_W  current stored-value balance
- maintenance  in  1  level; requests service mode
- pass_sensor  in  1  level; passenger has cleared the gate
- open  out  1  gate actuator
- disp  out  3  000 idle, 001 insufficient funds, 010 invalid card, 100 open/balance, 101 open/monthly, 111 out of service
- sound  out  2  00 none, 01 error beeps, 10 pass beep
- bal_we  out  1  one-cycle balance write-back strobe
- bal_out  out  BAL_W  new balance; registered, held until the next charge
- busy  out  1  1 in every state except IDLE and SERV

## Operation
- States: IDLE, CHECK, CHARGE, OPEN, MSG, SERV.
- IDLE: if maintenance=1, go to SERV. Maintenance wins over a tap in the same cycle, and that tap is dropped. Otherwise, on tap=1, capture card_* into registers and go to CHECK.
- CHECK: uses the captured values only.
  - Inactive card → MSG with code 010.
  - Monthly pass → OPEN with disp 101 and no charge.
  - Otherwise fare = CONC_FARE if concession, else FARE.
  - card_bal ≥ fare → CHARGE. Otherwise → MSG with code 001.
- Priority in CHECK: active check first, then monthly, then concession. Monthly overrides balance and concession.
- CHARGE: lasts one cycle.
  - bal_we=1.
  - bal_out ← card_bal − fare, unsigned, BAL_W bits. Underflow cannot occur.
  - An exact-fare balance gives bal_out=0.
  - Next state is OPEN with disp 100.
- OPEN:
  - open=1 and disp = the selected code.
  - sound=10 for the first BEEP_CYC cycles.
  - Exit to IDLE when pass_sensor=1, or after OPEN_CYC cycles in OPEN, whichever comes first.
  - A tap in OPEN (anti-passback) causes no charge and no state change. sound=01 for BEEP_CYC cycles from the next cycle, restarting the beep counter; the error beep overrides the pass beep.
- MSG:
  - disp = the error code and open=0.
  - sound=01 for the first BEEP_CYC cycles.
  - Go to IDLE after MSG_CYC cycles. Taps are ignored silently.
- SERV:
  - disp=111 and open=0.
  - A tap gives sound=01 for BEEP_CYC cycles.
  - Go to IDLE when maintenance=0.
- Maintenance raised in any other state does not abort the transaction. It is honoured on the next IDLE cycle.
- One shared down-counter of width $clog2(max(OPEN_CYC,MSG_CYC)+1) times OPEN and MSG; one beep counter of width $clog2(BEEP_CYC+1) times sound.

## Timing
- Reset: state IDLE; open=0, disp=000, sound=00, bal_we=0, bal_out=0, busy=0; all counters and captured registers 0. Reset in any state (including OPEN) forces these values on the cycle after rst is sampled high.
- All outputs are registered or decoded from registered state. No combinational path runs from inputs to outputs.
- Counting from tap at cycle T:
  - CHECK at T+1.
  - Pay path: CHARGE at T+2 (bal_we=1), OPEN from T+3.
  - Monthly path: OPEN from T+2.
  - Error path: MSG from T+2.
- OPEN with no sensor: open=1 for exactly OPEN_CYC cycles, then IDLE.
- pass_sensor first seen in OPEN cycle k: open is still 1 that cycle and 0 in the next.
- MSG lasts exactly MSG_CYC cycles.
- Back-to-back: a tap is accepted in the first IDLE cycle after OPEN/MSG.
- bal_out stays stable after CHARGE until the next CHARGE or reset.

## Test plan
- Defaults, card_bal=1000, standard tap at T → bal_we=1 at T+2 with bal_out=690; open=1 over T+3..T+10; sound=10 over T+3..T+4; disp=100; IDLE at T+11.
- card_bal=205 with concession → bal_out=0, gate opens. card_bal=309 standard → no bal_we; disp=001 and sound=01 at T+2..T+3; disp=001 at T+2..T+5; then idle.
- Monthly, card_bal=0 → no bal_we; disp=101 and open=1 from T+2. pass_sensor=1 at T+4 → open=0 at T+5.
- card_active=0 with monthly=1 → disp=010 for 4 cycles; open never asserts.
- Second tap during OPEN → sound=01 for 2 cycles; bal_we stays 0; the open window is unchanged.
- maintenance=1 with a simultaneous tap in IDLE → SERV, disp=111, no CHECK. A tap in SERV gives sound=01 for 2 cycles. Dropping maintenance returns to IDLE. rst asserted mid-OPEN → all outputs at reset values the next cycle.
